sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//  Shares the single external 16-bit async SRAM between three byte-wide requesters:
//   - the flash loader (write only);
//   - the NES CPU (read/write);
//   - the NES PPU (read only).
//  Sequences each access as SETUP/ACTIVE/HOLD phases, drives byte lanes and captures read data.
//  Sits between main_mem's request logic and the ADR/DAT/RAMOE/RAMWE/RAMCS pins.
// PARAMETERS
//  ADDR_W         19  byte address width; SRAM word address = addr[ADDR_W-1:1]
//  ACCESS_CYCLES  2   cycles OE_n/WE_n held low per access; legal range 1..15
// PORTS
//  clock        in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  ldr_req      in   1       loader request (level); held until ldr_ack
//  ldr_addr     in   ADDR_W  loader byte address
//  ldr_wdata    in   8       loader write byte
//  ldr_ack      out  1       one-cycle completion pulse
//  cpu_req      in   1       CPU request (level)
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU byte address
//  cpu_wdata    in   8       CPU write byte
//  cpu_ack      out  1       one-cycle completion pulse
//  ppu_req      in   1       PPU read request (level)
//  ppu_addr     in   ADDR_W  PPU byte address
//  ppu_ack      out  1       one-cycle completion pulse
//  rd_data      out  8       read byte; valid in the cycle cpu_ack/ppu_ack is high
//  busy         out  1       high in any state other than IDLE
//  sram_adr     out  ADDR_W-1  SRAM word address
//  sram_dq_o    out  16      write data, {wdata,wdata}
//  sram_dq_oe   out  1       data-pin drive enable
//  sram_dq_i    in   16      SRAM read data
//  sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out 1  active-low strobes
// BEHAVIOUR
//  Reset (asynchronous, immediate, also mid-access):
//   - state=IDLE; all *_n outputs=1; sram_dq_oe=0; acks=0; busy=0.
//   - rd_data=0; sram_adr=0; rr_last=PPU.
//  FSM: IDLE -> SETUP -> ACTIVE(xACCESS_CYCLES) -> HOLD -> IDLE.
//  IDLE: at a clock edge with any request high, grant and latch addr, we, wdata.
//   - Loader has fixed top priority.
//   - CPU vs PPU: round-robin; grant the one not in rr_last, update rr_last on grant.
//  SETUP: cs_n=0; adr valid; lane strobe low (addr[0]=0 -> lb_n, 1 -> ub_n); oe_n=we_n=1.
//   - Write: dq_oe=1.
//  ACTIVE: read -> oe_n=0; write -> we_n=0, dq_oe=1.
//   - Read data captured on the edge leaving the last ACTIVE cycle.
//   - Captured lane: addr[0] ? dq_i[15:8] : dq_i[7:0].
//  HOLD: oe_n=we_n=1; cs_n, adr, lane strobe and dq_oe still held.
//   - The granted requester's ack=1 for exactly this cycle; rd_data updated in this cycle.
//  Latency: grant edge k -> ack high in cycle after edge k+ACCESS_CYCLES+1.
//   - With ACCESS_CYCLES=2, ack comes 3 edges after grant.
//   - Access period = ACCESS_CYCLES+3 cycles including the return to IDLE.
//  Handshake: requester drops req at the edge where it samples ack=1.
//   - A req still high in IDLE after ack is treated as a new request.
//  Request inputs are ignored outside IDLE.
//  Data is never driven while oe_n=0: dq_oe=0 for all read phases.
//  rd_data holds its value between reads; loader and CPU writes never change it.
//  Simultaneous loader+CPU+PPU: loader served every time until ldr_req falls.
// TESTING
//  T1 reset: assert reset_n=0 mid-ACTIVE write -> same cycle we_n=1, cs_n=1, dq_oe=0, busy=0.
//  T2 CPU read, addr=0x00003, sram_dq_i=16'hA55A, ACCESS_CYCLES=2:
//   -> sram_adr=0x00001, ub_n=0, lb_n=1, oe_n low 2 cycles.
//   -> cpu_ack 3 edges after grant with rd_data=8'hA5.
//  T3 CPU write, addr=0x00010, wdata=8'h3C:
//   -> lb_n=0, ub_n=1, dq_o=16'h3C3C, we_n low 2 cycles, dq_oe high SETUP..HOLD.
//  T4 cpu_req and ppu_req held high from reset:
//   -> grants alternate CPU, PPU, CPU, PPU; each gets exactly one ack per access.
//  T5 ldr_req, cpu_req, ppu_req all high for 4 accesses, then ldr_req drops:
//   -> 4 ldr_acks, then CPU, then PPU.
//  T6 PPU read followed by a CPU write:
//   -> rd_data unchanged after cpu_ack; ppu_ack never coincides with cpu_ack.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
//  Shares one external 16-bit async SRAM between three byte-wide requesters:
//  the flash loader (write only, fixed top priority), the NES CPU (read/write)
//  and the NES PPU (read only). CPU and PPU alternate round-robin when both ask.
//  Each access runs IDLE -> SETUP -> ACTIVE (xACCESS_CYCLES) -> HOLD -> IDLE.
//  Byte lanes are chosen by addr[0]; writes replicate the byte on both lanes.
// Ports
//  clock, reset_n                 system clock, async active-low reset
//  ldr_req/addr/wdata, ldr_ack    loader write channel, ack is a 1-cycle pulse
//  cpu_req/we/addr/wdata, cpu_ack CPU read/write channel
//  ppu_req/addr, ppu_ack          PPU read channel
//  rd_data                        read byte, valid while cpu_ack/ppu_ack is high
//  busy                           high whenever an access is in flight
//  sram_*                         SRAM pins (word address, data, active-low strobes)
module sram_arbiter #(
   parameter int ADDR_W        = 19,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_wdata,
   output logic              ldr_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic              ppu_ack,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic [ADDR_W-2:0] sram_adr,
   output logic [15:0]       sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [15:0]       sram_dq_i,
   output logic              sram_cs_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD} state_t;

   localparam logic [1:0] G_LDR = 2'd0;
   localparam logic [1:0] G_CPU = 2'd1;
   localparam logic [1:0] G_PPU = 2'd2;
   localparam logic [3:0] C_LAST = 4'(ACCESS_CYCLES - 1);

   state_t              r_state, w_next;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [7:0]          r_wdata;
   logic [1:0]          r_gnt;
   logic                r_rr_ppu;      // 1: PPU was the last CPU/PPU grant
   logic [7:0]          r_rd_data;

   logic                w_any_req;
   logic [1:0]          w_sel;
   logic                w_last_active;

   assign w_any_req     = ldr_req | cpu_req | ppu_req;
   assign w_last_active = (r_state == S_ACTIVE) && (r_cnt == C_LAST);

   // Loader always wins; between CPU and PPU, the one not served last wins.
   always_comb begin
      w_sel = G_PPU;
      if (ldr_req)
         w_sel = G_LDR;
      else if (cpu_req && (!ppu_req || r_rr_ppu))
         w_sel = G_CPU;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_next = S_SETUP;
         S_SETUP:  w_next = S_ACTIVE;
         S_ACTIVE: if (r_cnt == C_LAST) w_next = S_HOLD;
         S_HOLD:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_gnt     <= G_LDR;
         r_rr_ppu  <= 1'b1;
         r_rd_data <= '0;
      end else begin
         if (r_state == S_SETUP)
            r_cnt <= '0;
         else if (r_state == S_ACTIVE)
            r_cnt <= r_cnt + 4'd1;

         if (r_state == S_IDLE && w_any_req) begin
            r_gnt <= w_sel;
            case (w_sel)
               G_LDR: begin
                  r_addr  <= ldr_addr;
                  r_we    <= 1'b1;
                  r_wdata <= ldr_wdata;
               end
               G_CPU: begin
                  r_addr   <= cpu_addr;
                  r_we     <= cpu_we;
                  r_wdata  <= cpu_wdata;
                  r_rr_ppu <= 1'b0;
               end
               default: begin
                  r_addr   <= ppu_addr;
                  r_we     <= 1'b0;
                  r_rr_ppu <= 1'b1;
               end
            endcase
         end

         // Capture on the edge leaving the final ACTIVE cycle, reads only.
         if (w_last_active && !r_we)
            r_rd_data <= r_addr[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
      end
   end

   // Pin strobes decode straight from the state register so an async reset
   // releases the bus in the same cycle.
   always_comb begin
      busy       = (r_state != S_IDLE);
      sram_cs_n  = !busy;
      sram_ub_n  = !(busy && r_addr[0]);
      sram_lb_n  = !(busy && !r_addr[0]);
      sram_oe_n  = !((r_state == S_ACTIVE) && !r_we);
      sram_we_n  = !((r_state == S_ACTIVE) && r_we);
      sram_dq_oe = busy && r_we;
      ldr_ack    = (r_state == S_HOLD) && (r_gnt == G_LDR);
      cpu_ack    = (r_state == S_HOLD) && (r_gnt == G_CPU);
      ppu_ack    = (r_state == S_HOLD) && (r_gnt == G_PPU);
   end

   assign sram_adr  = r_addr[ADDR_W-1:1];
   assign sram_dq_o = {r_wdata, r_wdata};
   assign rd_data   = r_rd_data;

endmodule
